// File: rtl/sum3d_pkg.sv
// sum3d_pkg: shared tensor geometry and loader state encoding for the sum3d feeder.
package sum3d_pkg;
  localparam int ELEM_W      = 8;
  localparam int DIM0        = 2;
  localparam int DIM1        = 3;
  localparam int DIM2        = 2;
  localparam int N_ELEM      = DIM0 * DIM1 * DIM2;
  localparam int FRAME_BEATS = 2 * N_ELEM;
  typedef enum logic [1:0] {LOAD, DRAIN, PRESENT} state_t;
endpackage

// File: rtl/sum3d_elem_buf.sv
// sum3d_elem_buf: N_ELEM x ELEM_W register file, indexed byte write, flattened read bus.
module sum3d_elem_buf #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [$clog2(N_ELEM)-1:0]   idx_i,
  input  logic [ELEM_W-1:0]           wdata_i,
  output logic [N_ELEM*ELEM_W-1:0]    data_o
);
  logic [N_ELEM-1:0][ELEM_W-1:0] mem_q;
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else if (we_i) mem_q[idx_i] <= wdata_i;
  end
  assign data_o = mem_q;
endmodule

// File: rtl/sum3d_loader.sv
// sum3d_loader: assembles byte beats into a/b tensor frames and hands them to sum3d.
module sum3d_loader #(
  parameter int ELEM_W = sum3d_pkg::ELEM_W,
  parameter int N_ELEM = sum3d_pkg::N_ELEM,
  parameter int FCNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [N_ELEM*ELEM_W-1:0]  out_a,
  output logic [N_ELEM*ELEM_W-1:0]  out_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err,
  output logic [FCNT_W-1:0]         frame_cnt
);
  import sum3d_pkg::*;
  localparam int BEATS = 2 * N_ELEM;
  localparam int CW    = $clog2(BEATS);
  localparam int IW    = $clog2(N_ELEM);
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              rdy_q, vld_q, err_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              xfer, last_beat, in_a, we_a, we_b;
  logic [IW-1:0]     idx_a, idx_b;
  assign xfer      = in_valid && rdy_q;
  assign last_beat = cnt_q == CW'(BEATS - 1);
  assign in_a      = cnt_q < CW'(N_ELEM);
  assign we_a      = xfer && state_q == LOAD && in_a;
  assign we_b      = xfer && state_q == LOAD && !in_a;
  assign idx_a     = cnt_q[IW-1:0];
  assign idx_b     = IW'(cnt_q - CW'(N_ELEM));
  // A mismatch between in_last and the 24th beat is a framing error in either direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        LOAD: begin
          rdy_q <= 1'b1;
          if (xfer) begin
            cnt_q <= (in_last || last_beat) ? '0 : cnt_q + 1'b1;
            err_q <= in_last != last_beat;
            if (last_beat) begin
              state_q <= in_last ? PRESENT : DRAIN;
              vld_q   <= in_last;
              rdy_q   <= !in_last;
            end
          end
        end
        DRAIN: if (xfer && in_last) state_q <= LOAD;
        PRESENT: if (out_ready) begin
          state_q <= LOAD;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          fcnt_q  <= fcnt_q + 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end
  sum3d_elem_buf #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_buf_a (
    .clk(clk), .rst(rst), .we_i(we_a), .idx_i(idx_a), .wdata_i(in_data), .data_o(out_a)
  );
  sum3d_elem_buf #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_buf_b (
    .clk(clk), .rst(rst), .we_i(we_b), .idx_i(idx_b), .wdata_i(in_data), .data_o(out_b)
  );
  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign err       = err_q;
  assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_sum3d_loader.sv
// tb_sum3d_loader: randomized scoreboard bench for sum3d_loader with a frame-level reference model.
module tb_sum3d_loader;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, err, in_ready2, out_valid2, err2;
  logic [95:0] out_a, out_b, out_a2, out_b2;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_cnt2;
  always #5 clk = ~clk;
  sum3d_loader u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .frame_cnt(frame_cnt)
  );
  sum3d_loader #(.FCNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready2), .out_a(out_a2), .out_b(out_b2), .out_valid(out_valid2),
    .out_ready(out_ready), .err(err2), .frame_cnt(frame_cnt2)
  );
  typedef struct {
    logic [95:0] a;
    logic [95:0] b;
    int          due;
    int          sum;
  } frame_t;
  frame_t     fq[$];
  int         eq[$];
  logic [7:0] cur[$];
  bit         draining = 0;
  int         cyc = 0, or_mode = 0;
  int         vectors = 0, miscompares = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // Frame-level reference: collect accepted beats, decide frame/error/drain from counts alone.
  task automatic model(input logic [7:0] d, input logic l);
    frame_t f;
    if (draining) begin
      if (l) draining = 0;
    end else begin
      cur.push_back(d);
      if (cur.size() == 24 && l) begin
        f.a = '0; f.b = '0; f.sum = 0; f.due = cyc + 1;
        for (int i = 0; i < 12; i++) begin
          f.a[8*i +: 8] = cur[i];
          f.b[8*i +: 8] = cur[12+i];
          f.sum += int'(cur[i]) + int'(cur[12+i]);
        end
        fq.push_back(f);
        cur.delete();
      end else if (l || cur.size() == 24) begin
        eq.push_back(cyc + 1);
        draining = !l;
        cur.delete();
      end
    end
  endtask
  task automatic cyc_drive(input logic v, input logic [7:0] d, input logic l, output bit x);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = or_mode == 0 ? 1'b1 : or_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    x = v && in_ready;
    if (x) model(d, l);
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    bit x;
    repeat (n) cyc_drive(1'b0, 8'($urandom), 1'($urandom), x);
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    bit x = 0;
    int t = 0;
    while (!x && t < 200) begin
      cyc_drive(1'b1, d, l, x);
      t++;
    end
    if (!x) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
    end
  endtask
  task automatic frame(input int n, input int last_at, input int kind, input logic [7:0] c);
    for (int i = 0; i < n; i++) begin
      if (or_mode == 2 && $urandom_range(0, 3) == 0) idle(1);
      send(kind == 0 ? 8'(i + 1) : kind == 1 ? c : 8'($urandom), i + 1 == last_at);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fq.delete(); eq.delete(); cur.delete(); draining = 0;
    chk("rst_out_a", out_a, '0);
    chk("rst_out_b", out_b, '0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("rdy_after_rst", in_ready, 1);
  endtask
  bit          prev_v = 0, ho = 0;
  logic [95:0] held_a, held_b;
  int          exp_fcnt = 0;
  always @(negedge clk) begin : monitor
    frame_t f;
    int     s;
    if (rst) begin
      prev_v = 0; ho = 0; exp_fcnt = 0;
    end else begin
      if (ho) begin
        chk("frame_cnt", frame_cnt, 96'(exp_fcnt & 16'hFFFF));
        chk("frame_cnt_w2", frame_cnt2, 96'(exp_fcnt % 4));
        chk("handoff_valid_low", out_valid, 0);
        chk("handoff_ready_high", in_ready, 1);
        ho = 0;
      end
      if (err) begin
        if (eq.size() == 0) chk("unexpected_err", err, 0);
        else chk("err_cycle", 96'(cyc), 96'(eq.pop_front()));
      end
      if (out_valid) chk("ready_low_while_valid", in_ready, 0);
      if (out_valid && !prev_v) begin
        if (fq.size() == 0) chk("unexpected_valid", out_valid, 0);
        else begin
          f = fq.pop_front();
          s = 0;
          for (int i = 0; i < 12; i++) s += int'(out_a[8*i +: 8]) + int'(out_b[8*i +: 8]);
          chk("out_a", out_a, f.a);
          chk("out_b", out_b, f.b);
          chk("valid_latency", 96'(cyc), 96'(f.due));
          chk("sum3d_sum", 96'(s), 96'(f.sum));
        end
      end else if (out_valid) begin
        chk("hold_a", out_a, held_a);
        chk("hold_b", out_b, held_b);
      end
      if (out_valid && out_ready) begin
        ho = 1;
        exp_fcnt++;
      end
      prev_v = out_valid;
      held_a = out_a;
      held_b = out_b;
    end
  end
  initial begin
    bit x;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    or_mode = 0;
    frame(24, 24, 0, 8'h00);
    idle(3);
    or_mode = 1;
    frame(24, 24, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc_drive(1'b1, 8'h55, 1'b1, x);
      chk("stall_beat_ignored", x, 0);
    end
    or_mode = 0;
    idle(3);
    frame(5, 5, 2, 8'h00);
    frame(24, 24, 1, 8'hAA);
    idle(3);
    frame(30, 30, 2, 8'h00);
    frame(24, 24, 2, 8'h00);
    idle(3);
    frame(10, 0, 2, 8'h00);
    do_reset();
    frame(24, 24, 1, 8'hFF);
    idle(3);
    or_mode = 1;
    frame(24, 24, 2, 8'h00);
    idle(2);
    do_reset();
    or_mode = 0;
    for (int i = 0; i < 4; i++) frame(24, 24, 2, 8'h00);
    idle(3);
    or_mode = 2;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: frame(int'($urandom_range(1, 23)), -1, 2, 8'h00);
        1: frame(int'($urandom_range(25, 30)), -1, 2, 8'h00);
        default: frame(24, 24, 2, 8'h00);
      endcase
      if (!draining && cur.size() == 0) continue;
      send(8'($urandom), 1'b1);
    end
    or_mode = 0;
    idle(30);
    chk("frames_left", 96'(fq.size()), 0);
    chk("errs_left", 96'(eq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
